// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg -- shared definitions for the sequential ALU.
//   * opcode constants (4-bit ALUOp encoding)
//   * FSM state encoding used by seq_alu
//   * bit positions inside the 4-bit flags vector {err, ovf, carry, zero}
//   * engine mode selector for alu_iter_muldiv
// No ports; imported by seq_alu and alu_iter_muldiv.
// -----------------------------------------------------------------------------
package alu_pkg;

  // Opcodes
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_SAR = 4'b1010;
  localparam logic [3:0] OP_CMP = 4'b1011;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit indices inside flags
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ERR   = 3;

  // Iterative engine mode
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/alu_iter_muldiv.sv
// -----------------------------------------------------------------------------
// alu_iter_muldiv -- shared N-iteration engine for unsigned shift-add multiply
// and unsigned restoring divide.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start_i    : load operands and begin (one-cycle pulse, only while idle)
//   mode_i     : MODE_MUL or MODE_DIV, sampled with start_i
//   stall_i    : freeze counter and datapath for this cycle
//   a_i, b_i   : operands, sampled with start_i
//   busy_o     : an operation is in progress
//   done_o     : the final iteration happens on this rising edge
//   res_o      : value the {hi, lo} pair takes at this edge; valid with done_o
//                MUL -> {product_hi, product_lo}, DIV -> {remainder, quotient}
//
// Both modes share one {hi, lo} register pair:
//   MUL: hi = partial product, lo = multiplier shifting out to the right
//   DIV: hi = partial remainder, lo = dividend shifting out / quotient in
// -----------------------------------------------------------------------------
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           mode_i,
  input  logic           stall_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*N-1:0] res_o
);

  localparam int SHW = $clog2(N);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(N - 1);

  logic           busy_q, busy_d;
  logic           mode_q, mode_d;
  logic [SHW-1:0] cnt_q,  cnt_d;
  logic [N-1:0]   hi_q,   hi_d;
  logic [N-1:0]   lo_q,   lo_d;
  logic [N-1:0]   m_q,    m_d;   // multiplicand or divisor

  logic [N:0]     mul_sum;
  logic [N:0]     rem_sh;
  logic [N:0]     div_diff;
  logic [N-1:0]   iter_hi;
  logic [N-1:0]   iter_lo;

  // One iteration of either algorithm, computed from the current registers.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(N+1){1'b0}});
    rem_sh   = {hi_q, lo_q[N-1]};
    div_diff = rem_sh - {1'b0, m_q};
    iter_hi  = hi_q;
    iter_lo  = lo_q;
    if (mode_q == MODE_MUL) begin
      // Add-then-shift-right of {carry, hi, lo}
      iter_hi = mul_sum[N:1];
      iter_lo = {mul_sum[0], lo_q[N-1:1]};
    end else begin
      // A set top bit of the N+1-bit difference means the trial subtract
      // went negative, so the shifted remainder is restored.
      if (!div_diff[N]) begin
        iter_hi = div_diff[N-1:0];
        iter_lo = {lo_q[N-2:0], 1'b1};
      end else begin
        iter_hi = rem_sh[N-1:0];
        iter_lo = {lo_q[N-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    m_d    = m_q;
    if (start_i) begin
      busy_d = 1'b1;
      mode_d = mode_i;
      cnt_d  = '0;
      hi_d   = '0;
      if (mode_i == MODE_DIV) begin
        lo_d = a_i;
        m_d  = b_i;
      end else begin
        lo_d = b_i;
        m_d  = a_i;
      end
    end else if (busy_q && !stall_i) begin
      hi_d = iter_hi;
      lo_d = iter_lo;
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      mode_q <= MODE_MUL;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
    end else begin
      busy_q <= busy_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      m_q    <= m_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && !stall_i && (cnt_q == CNT_LAST);
  assign res_o  = {iter_hi, iter_lo};

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- sequential ALU with a valid/ready operation port and a
// valid/ready result port.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   enable       : global advance; low freezes all state
//   in_valid     : A, B, ALUOp presented
//   in_ready     : high only in IDLE
//   A, B         : N-bit operands
//   ALUOp        : 4-bit opcode (see alu_pkg)
//   result       : registered 2N-bit result
//   data_valid   : high only in DONE
//   out_ready    : consumer takes the result
//   flags        : registered {err, ovf, carry, zero}
//   dbg_state_o  : current FSM state
//
// Handshake: an operation is accepted on a rising edge where
// in_valid & in_ready & enable; a result retires on a rising edge where
// data_valid & out_ready & enable. Neither side is queued: in_valid seen while
// in_ready is low is simply dropped, and result/flags hold until retire.
// -----------------------------------------------------------------------------
module seq_alu
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic [3:0]     ALUOp,
  output logic [2*N-1:0] result,
  output logic           data_valid,
  input  logic           out_ready,
  output logic [3:0]     flags,
  output logic [1:0]     dbg_state_o
);

  localparam int SHW = $clog2(N);

  if (N < 4 || N > 32 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("seq_alu: N must be a power of two between 4 and 32");
  end

  state_e         state_q, state_d;
  logic [2*N-1:0] result_q, result_d;
  logic [3:0]     flags_q, flags_d;

  logic           accept;
  logic           iter_op;
  logic           eng_start;
  logic           eng_busy;
  logic           eng_done;
  logic [2*N-1:0] eng_res;

  logic [SHW-1:0] sh_amt;
  logic [N:0]     add_s;
  logic [N-1:0]   sub_s;
  logic [2*N-1:0] sc_res;
  logic           sc_carry;
  logic           sc_ovf;
  logic           sc_err;

  // Single-cycle datapath; operands are consumed on the accept edge, so the
  // result is captured directly from the live inputs.
  always_comb begin
    sh_amt   = B[SHW-1:0];
    add_s    = {1'b0, A} + {1'b0, B};
    sub_s    = A - B;
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_err   = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        sc_res[N:0] = add_s;
        sc_carry    = add_s[N];
        sc_ovf      = (A[N-1] == B[N-1]) && (add_s[N-1] != A[N-1]);
      end
      OP_SUB: begin
        sc_res[N-1:0] = sub_s;
        sc_carry      = (A < B);
        sc_ovf        = (A[N-1] != B[N-1]) && (sub_s[N-1] != A[N-1]);
      end
      OP_MUL: sc_res = '0;  // always iterative
      OP_DIV: begin
        // Only reaches the result register for B == 0
        sc_res = {A, {N{1'b1}}};
        sc_err = 1'b1;
      end
      OP_AND: sc_res[N-1:0] = A & B;
      OP_OR:  sc_res[N-1:0] = A | B;
      OP_XOR: sc_res[N-1:0] = A ^ B;
      OP_NOT: sc_res[N-1:0] = ~A;
      OP_SHL: sc_res[N-1:0] = A << sh_amt;
      OP_SHR: sc_res[N-1:0] = A >> sh_amt;
      OP_SAR: sc_res[N-1:0] = $unsigned($signed(A) >>> sh_amt);
      OP_CMP: begin
        sc_res[0] = (A < B);
        sc_res[1] = ($signed(A) < $signed(B));
      end
      default: sc_err = 1'b1;
    endcase
  end

  assign iter_op = (ALUOp == OP_MUL) || ((ALUOp == OP_DIV) && (B != '0));
  assign accept  = enable && in_valid && (state_q == ST_IDLE);

  // Next-state, result and flag capture
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    eng_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (iter_op) begin
            eng_start = 1'b1;
            state_d   = ST_BUSY;
          end else begin
            state_d             = ST_DONE;
            result_d            = sc_res;
            flags_d             = '0;
            flags_d[FLAG_ERR]   = sc_err;
            flags_d[FLAG_OVF]   = sc_ovf;
            flags_d[FLAG_CARRY] = sc_carry;
            flags_d[FLAG_ZERO]  = (sc_res == '0);
          end
        end
      end
      ST_BUSY: begin
        if (eng_done) begin
          state_d            = ST_DONE;
          result_d           = eng_res;
          flags_d            = '0;
          flags_d[FLAG_ZERO] = (eng_res == '0);
        end
      end
      ST_DONE: begin
        if (enable && out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  alu_iter_muldiv #(.N(N)) u_engine (
    .clk     (clk),
    .rst     (rst),
    .start_i (eng_start),
    .mode_i  ((ALUOp == OP_DIV) ? MODE_DIV : MODE_MUL),
    .stall_i (!enable),
    .a_i     (A),
    .b_i     (B),
    .busy_o  (eng_busy),
    .done_o  (eng_done),
    .res_o   (eng_res)
  );

  assign in_ready    = (state_q == ST_IDLE);
  assign data_valid  = (state_q == ST_DONE);
  assign result      = result_q;
  assign flags       = flags_q;
  assign dbg_state_o = state_q;

  // eng_busy mirrors ST_BUSY; kept for observability only
  logic unused_busy;
  assign unused_busy = eng_busy;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter N, default 8, meaning operand width in bits; legal values are 4 to 32 and must be a power of two.
REQ-002 Parameter SHW = log2(N), derived and not overridable, meaning the shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 enable  input  1  global advance; while low, all state holds and nothing is accepted or retired.
REQ-006 in_valid  input  1  operands and opcode presented.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 A, B  input  N each  operands, treated as unsigned unless an opcode says otherwise.
REQ-009 ALUOp  input  4  opcode.
REQ-010 result  output  2N  registered result.
REQ-011 data_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 flags  output  4  {err, ovf, carry, zero}, registered alongside result.

Function
REQ-014 Accept condition: in_valid & in_ready & enable at a rising edge; the block SHALL latch A, B and ALUOp on that edge.
REQ-015 FSM states: IDLE, BUSY, DONE; in_ready=1 only in IDLE; data_valid=1 only in DONE.
REQ-016 Retire condition: data_valid & out_ready & enable, which moves DONE to IDLE; result and flags hold stable in DONE until retire.
REQ-017 Single-cycle ops move IDLE to DONE; data_valid rises one edge after accept.
REQ-018 Opcode 0000 ADD: result = zero-extended A+B (N+1 bits); carry = carry-out; ovf = signed overflow.
REQ-019 Opcode 0001 SUB: result[N-1:0] = A-B mod 2^N, upper bits 0; carry = borrow (A<B); ovf = signed overflow.
REQ-020 Opcode 0010 MUL: unsigned, full 2N-bit product via iterative shift-add; IDLE to BUSY for N cycles, then DONE; data_valid N+1 edges after accept.
REQ-021 Opcode 0011 DIV: unsigned restoring division; result = {remainder[N-1:0], quotient[N-1:0]}; latency N+1 edges, as for MUL.
REQ-022 DIV with B=0 SHALL skip BUSY (single-cycle) with quotient all ones, remainder = A, err=1.
REQ-023 Opcodes 0100 AND, 0101 OR, 0110 XOR and 0111 NOT A: N-bit results, zero-extended.
REQ-024 Opcodes 1000 SHL, 1001 SHR (logical) and 1010 SAR: shift A by B[SHW-1:0]; N-bit results, zero-extended.
REQ-025 Opcode 1011 CMP: result[0] = (A<B) unsigned, result[1] = (A<B) signed, all other bits 0.
REQ-026 Opcodes 1100 to 1111 are illegal: result 0, err=1, single-cycle.
REQ-027 zero = (result==0) for every opcode; carry and ovf = 0 for every opcode except ADD and SUB; err = 0 except in REQ-022 and REQ-026.
REQ-028 enable low in BUSY freezes the iteration counter and datapath; the total latency grows by exactly the number of stalled cycles.
REQ-029 in_valid asserted while in_ready=0 is ignored; the block does not queue it.
REQ-030 Operand or opcode changes after accept SHALL NOT affect the operation in flight.

Reset
REQ-031 rst=1 immediately forces: state IDLE, result 0, flags 0, data_valid 0, in_ready 1, iteration counter 0.
REQ-032 Reset during BUSY or DONE aborts the operation; no data_valid follows for the aborted operation.
REQ-033 The first accept is possible on the first rising edge after rst deasserts.

Structure
REQ-034 Package alu_pkg SHALL hold the opcode constants, the FSM state encoding and the flag bit indices.
REQ-035 Sub-module alu_iter_muldiv SHALL hold the shared N-cycle shift-add/restoring engine, with start, mode, stall and done signals; seq_alu holds the FSM, single-cycle ops, flags and handshake.

Verification (N=8)
REQ-036 ADD A=0xDA B=0x2B -> one edge after accept: result=0x0105, carry=1, zero=0, ovf=0.
REQ-037 SUB A=0xDA B=0x2B -> result=0x00AF, carry=0; MUL A=0x04 B=0x78 -> result=0x01E0, data_valid exactly 9 edges after accept.
REQ-038 DIV A=0xDA B=0x2B -> result=0x0305 after 9 edges; DIV A=0x55 B=0x00 -> result=0x55FF, err=1, one edge.
REQ-039 MUL 0xFF*0xFF with enable low for 3 cycles mid-BUSY -> result=0xFE01 at 12 edges; in_valid with new operands during BUSY is ignored.
REQ-040 out_ready held low for 5 cycles in DONE -> result and flags stable; in_ready stays 0 until retire.
REQ-041 rst pulse mid-DIV -> all outputs 0, in_ready=1, no data_valid; the next ADD 0x01+0xFF gives 0x0100, carry=1.
